// File: rtl/uart_pkg.sv
// Shared types for the MMIO UART transmitter.
// Define UART_PARITY_EN to add the even-parity bit state.
package uart_pkg;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uartState_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uartState_e;
`endif

  localparam logic [2:0] DATA_OFS   = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-port bus slice seen by memory-mapped peripherals.
// Master is the MEM stage, slave is the peripheral.
interface mmio_uart_tx_if;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] readData;
  logic        hit;

  modport master (
    output address, writeData, memWrite, memRead,
    input  readData, hit
  );

  modport slave (
    input  address, writeData, memWrite, memRead,
    output readData, hit
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO with full/empty flags and same-cycle push/pop.
// Pushes into a full FIFO are ignored unless a pop frees a slot.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic doPush;
  logic doPop;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                 (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ONE;
      if (doPop)  rdPtr <= rdPtr + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS window, FIFO, serializer.
// Define UART_PARITY_EN to append an even-parity bit to each frame.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clock,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
`ifdef UART_PARITY_EN
  localparam logic       PAR_EN     = 1'b1;
  localparam uartState_e AFTER_DATA = PARITY;
`else
  localparam logic       PAR_EN     = 1'b0;
  localparam uartState_e AFTER_DATA = STOP;
`endif

  uartState_e  state;
  logic [15:0] baud;
  logic [2:0]  bitIdx;
  logic [7:0]  shifter;
  logic        ovf;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic        pop;
  logic        selStatus;
  logic        wrData;
  logic        wrStatus;
  logic        ovfEvent;
  logic        baudDone;
  logic        txNext;
  logic [31:0] statusWord;
  logic        unusedBits;

  assign bus.hit   = (bus.address[31:3] == BASE_ADDR[31:3]);
  assign selStatus = (bus.address[2] == STATUS_OFS[2]);
  assign wrData    = bus.hit & bus.memWrite & ~selStatus;
  assign wrStatus  = bus.hit & bus.memWrite & selStatus;
  assign pop       = (state == IDLE) & ~empty;
  assign ovfEvent  = wrData & full & ~pop;
  assign baudDone  = (baud == 16'd0);
  assign unusedBits = ^{bus.address[1:0], bus.writeData[31:8],
                        BASE_ADDR[2:0], DATA_OFS};

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (wrData),
    .pushData (bus.writeData[7:0]),
    .pop      (pop),
    .popData  (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    statusWord           = '0;
    statusWord[ST_FULL]  = full;
    statusWord[ST_EMPTY] = empty;
    statusWord[ST_BUSY]  = (state != IDLE);
    statusWord[ST_OVF]   = ovf;
    statusWord[ST_PAR]   = PAR_EN;
  end

  assign bus.readData =
    (bus.hit & bus.memRead & selStatus) ? statusWord : '0;

  // An overflow in the same cycle as a clear wins
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ovfEvent) begin
      ovf <= 1'b1;
    end else if (wrStatus && bus.writeData[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    txNext = 1'b1;
    unique case (state)
      START:   txNext = 1'b0;
      DATA:    txNext = shifter[bitIdx];
`ifdef UART_PARITY_EN
      PARITY:  txNext = ^shifter;
`endif
      default: txNext = 1'b1;
    endcase
  end

  // tx lags the state by one register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bitIdx  <= '0;
      shifter <= '0;
      tx      <= 1'b1;
    end else begin
      tx <= txNext;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            shifter <= head;
            baud    <= RELOAD;
            state   <= START;
          end
        end
        START: begin
          if (baudDone) begin
            baud   <= RELOAD;
            bitIdx <= '0;
            state  <= DATA;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (baudDone) begin
            baud   <= RELOAD;
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= AFTER_DATA;
          end else begin
            baud <= baud - 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (baudDone) begin
            baud  <= RELOAD;
            state <= STOP;
          end else begin
            baud <= baud - 16'd1;
          end
        end
`endif
        STOP: begin
          if (baudDone) begin
            baud  <= RELOAD;
            state <= IDLE;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode table, corner sequences, random traffic.
// Reference model predicts tx from frame start times and bit arithmetic.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [31:0] PARB = 32'h10;
`else
  localparam int NBITS = 10;
  localparam logic [31:0] PARB = 32'h0;
`endif
  localparam int FRAME = NBITS * C;

  logic clk;
  logic reset;
  logic tx;
  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] curByte;
  bit  haveFrame;
  int  frameAt;
  int  idleFrom;
  bit  ovfM;
  int  edgeCnt = 0;
  bit  txLog [int];
  logic [31:0] rdSample;
  logic hitSample;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h",
               name, edgeCnt, act, exp);
    end
  endtask

  function automatic bit mBusy();
    return haveFrame && (edgeCnt < frameAt + FRAME);
  endfunction

  function automatic logic [31:0] mStatus();
    logic [31:0] s;
    s = PARB;
    s[3] = ovfM;
    s[2] = mBusy();
    s[1] = (q.size() == 0);
    s[0] = (q.size() == D);
    return s;
  endfunction

  function automatic bit mHit(input logic [31:0] a);
    return a[31:3] == BASE[31:3];
  endfunction

  function automatic bit mTx();
    int j;
    if (!haveFrame) return 1'b1;
    if (edgeCnt < frameAt + 1 || edgeCnt > frameAt + FRAME)
      return 1'b1;
    j = (edgeCnt - frameAt - 1) / C;
    if (j == 0) return 1'b0;
    if (j <= 8) return curByte[j-1];
    if (NBITS == 11 && j == 9) return ^curByte;
    return 1'b1;
  endfunction

  task automatic mEdge(input logic [31:0] a, input logic [31:0] d,
                       input bit wr, input bit rs);
    bit popM;
    bit fullM;
    bit ev;
    edgeCnt++;
    if (rs) begin
      q.delete();
      haveFrame = 0;
      idleFrom = 0;
      ovfM = 0;
      return;
    end
    popM = (q.size() > 0) && (edgeCnt >= idleFrom);
    fullM = (q.size() == D);
    ev = 0;
    if (popM) begin
      curByte = q.pop_front();
      frameAt = edgeCnt;
      haveFrame = 1;
      idleFrom = edgeCnt + FRAME + 1;
    end
    if (mHit(a) && wr && !a[2]) begin
      if (!fullM || popM) q.push_back(d[7:0]);
      else ev = 1;
    end
    if (ev) ovfM = 1;
    else if (mHit(a) && wr && a[2] && d[3]) ovfM = 0;
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] d,
                       input bit wr, input bit rd, input bit rs);
    @(negedge clk);
    bus.address = a;
    bus.writeData = d;
    bus.memWrite = wr;
    bus.memRead = rd;
    reset = rs;
    #1;
    rdSample = bus.readData;
    hitSample = bus.hit;
    if (!rs) begin
      chk("hit", {31'b0, bus.hit}, {31'b0, mHit(a)});
      if (rd) begin
        chk("readData", bus.readData,
            (mHit(a) && a[2]) ? mStatus() : 32'h0);
      end
    end
    @(posedge clk);
    mEdge(a, d, wr, rs);
    #1;
    chk("tx", {31'b0, tx}, {31'b0, mTx()});
    txLog[edgeCnt] = tx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      if (q.size() == 0 && !mBusy()) break;
      idle(1);
    end
    chk("drainBound", {31'b0, mBusy()} | q.size(), 32'h0);
    idle(2);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    bit          rd;
    logic        expHit;
    logic [31:0] expRead;
  } vec_t;

  vec_t tbl[$];
  int n0;
  int busyCnt;
  bit seenBusy;
  bit allHigh;
  logic [7:0] a5Bits;
  int op;
  logic [31:0] ra;
  logic [31:0] rd32;

  initial begin
    bus.address = '0;
    bus.writeData = '0;
    bus.memWrite = 0;
    bus.memRead = 0;
    reset = 1;
    cycle(32'h0, 32'h0, 0, 0, 1);
    cycle(32'h0, 32'h0, 0, 0, 1);
    idle(2);

    tbl.push_back('{"stat",    BASE + 32'h4,   1, 1'b1, 32'h2 | PARB});
    tbl.push_back('{"statA1",  BASE + 32'h5,   1, 1'b1, 32'h2 | PARB});
    tbl.push_back('{"statA3",  BASE + 32'h7,   1, 1'b1, 32'h2 | PARB});
    tbl.push_back('{"data",    BASE,           1, 1'b1, 32'h0});
    tbl.push_back('{"dataA2",  BASE + 32'h2,   1, 1'b1, 32'h0});
    tbl.push_back('{"noRead",  BASE + 32'h4,   0, 1'b1, 32'h0});
    tbl.push_back('{"far",     BASE + 32'h100, 1, 1'b0, 32'h0});
    tbl.push_back('{"below",   BASE - 32'h4,   1, 1'b0, 32'h0});
    tbl.push_back('{"above",   BASE + 32'h8,   1, 1'b0, 32'h0});
    tbl.push_back('{"zero",    32'h0,          1, 1'b0, 32'h0});
    foreach (tbl[i]) begin
      cycle(tbl[i].addr, 32'h0, 0, tbl[i].rd, 0);
      chk({"tblHit_", tbl[i].name}, {31'b0, hitSample},
          {31'b0, tbl[i].expHit});
      chk({"tblRd_", tbl[i].name}, rdSample, tbl[i].expRead);
    end

    // single frame of 0xA5
    cycle(BASE, 32'h0000_00A5, 1, 0, 0);
    n0 = edgeCnt;
    idle(FRAME + 4);
    chk("latencyHigh", {31'b0, txLog[n0+1]}, 32'h1);
    chk("latencyLow", {31'b0, txLog[n0+2]}, 32'h0);
    a5Bits = 8'b1010_0101;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("a5bit%0d", j),
          {31'b0, txLog[n0+2+C*(j+1)+1]}, {31'b0, a5Bits[j]});
    end
    chk("a5bit9", {31'b0, txLog[n0+2+C*9+1]},
        (NBITS == 11) ? 32'h0 : 32'h1);
    chk("a5stop", {31'b0, txLog[n0+2+C*(NBITS-1)+1]}, 32'h1);
    cycle(BASE + 32'h4, 32'h0, 0, 1, 0);
    chk("statusDone", rdSample, 32'h2 | PARB);

    // six back-to-back stores overflow a depth-4 FIFO
    for (int i = 0; i < 6; i++) cycle(BASE, 32'h10 + i, 1, 0, 0);
    cycle(BASE + 32'h4, 32'h0, 0, 1, 0);
    chk("ovfStatus", rdSample, 32'hD | PARB);
    chk("queued", q.size(), 32'd4);
    cycle(BASE + 32'h4, 32'h7, 1, 0, 0);
    cycle(BASE + 32'h4, 32'h0, 0, 1, 0);
    chk("noClear", rdSample, 32'hD | PARB);
    cycle(BASE + 32'h4, 32'h8, 1, 0, 0);
    cycle(BASE + 32'h4, 32'h0, 0, 1, 0);
    chk("ovfClear", rdSample, 32'h5 | PARB);
    cycle(BASE + 32'h3, 32'h55, 1, 0, 0);
    cycle(BASE + 32'h4, 32'h0, 0, 1, 0);
    chk("ovfAgain", rdSample, 32'hD | PARB);
    drain();

    // frame length and parity bit for 0x07
    cycle(BASE, 32'h07, 1, 0, 0);
    n0 = edgeCnt;
    busyCnt = 0;
    seenBusy = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(BASE + 32'h4, 32'h0, 0, 1, 0);
      if (rdSample[2]) begin
        busyCnt++;
        seenBusy = 1;
      end else if (seenBusy) begin
        break;
      end
    end
    chk("frameLen", busyCnt, FRAME);
    chk("b07d7", {31'b0, txLog[n0+2+C*8+1]}, 32'h0);
    chk("b07bit9", {31'b0, txLog[n0+2+C*9+1]}, 32'h1);
    drain();

    // reset 15 cycles into a frame with a byte queued
    cycle(BASE, 32'h00, 1, 0, 0);
    cycle(BASE, 32'h3C, 1, 0, 0);
    idle(14);
    cycle(32'h0, 32'h0, 0, 0, 1);
    chk("rstTx", {31'b0, tx}, 32'h1);
    cycle(BASE + 32'h4, 32'h0, 0, 1, 0);
    chk("rstStatus", rdSample, 32'h2 | PARB);
    n0 = edgeCnt;
    idle(60);
    allHigh = 1;
    for (int e = n0; e <= edgeCnt; e++) if (!txLog[e]) allHigh = 0;
    chk("rstNoFrames", {31'b0, allHigh}, 32'h1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      op = int'($urandom_range(0, 999));
      rd32 = $urandom;
      ra = BASE | 32'($urandom_range(0, 3));
      if (op < 2) begin
        cycle(32'h0, 32'h0, 0, 0, 1);
      end else if (op < 300) begin
        cycle(ra, rd32, 1, 0, 0);
      end else if (op < 420) begin
        cycle(ra | 32'h4, rd32, 0, 1, 0);
      end else if (op < 470) begin
        cycle(ra | 32'h4, rd32, 1, 0, 0);
      end else if (op < 500) begin
        cycle(ra, rd32, 0, 1, 0);
      end else if (op < 540) begin
        cycle(BASE + 32'h100 + 32'($urandom_range(0, 7)),
              rd32, 1, 1, 0);
      end else begin
        idle(1);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_FF00, meaning the 8-byte-aligned base of the register window.
REQ-002 Parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit, legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 8, meaning the transmit FIFO entry count, a power of two from 2 to 64.
REQ-004 Port clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port address  input  32  byte address from the EX/MEM data-port register.
REQ-007 Port writeData  input  32  store data from EX/MEM.
REQ-008 Port memWrite  input  1  store strobe from EX/MEM.
REQ-009 Port memRead  input  1  load strobe from EX/MEM.
REQ-010 Port readData  output  32  load data returned to the MEM/WB mux path.
REQ-011 Port hit  output  1  high when address falls in the window, so the top level can select readData over data_memory and suppress the memory write.
REQ-012 Port tx  output  1  serial line, idle high.

Function
REQ-013 Decode: hit = (address[31:3] == BASE_ADDR[31:3]); address[2]=0 selects DATA and address[2]=1 selects STATUS; address[1:0] is ignored.
REQ-014 DATA write (hit & memWrite & DATA): pushes writeData[7:0] into the FIFO.
- When the FIFO is full and no pop occurs that cycle, the byte is dropped and sticky OVF is set.
REQ-015 Push and pop in the same cycle while full succeeds, with no OVF.
REQ-016 STATUS read word is {28'b0, OVF, BUSY, EMPTY, FULL} in bits [3:0].
- BUSY = FSM not IDLE.
REQ-017 DATA read returns 32'h0000_0000.
REQ-018 readData is combinational from current state, and is zero when (hit & memRead) is low.
REQ-019 STATUS write with writeData[3]=1 clears OVF; a simultaneous overflow event has priority and leaves OVF set.
REQ-020 FSM states IDLE, START, DATA, STOP, plus PARITY under REQ-030.
REQ-021 IDLE: if FIFO non-empty, pop the head into the shift register and enter START; tx goes low from the next edge.
REQ-022 Each state holds for exactly CLKS_PER_BIT cycles, timed by a baud down-counter reloaded to CLKS_PER_BIT-1 on each state or bit change.
REQ-023 DATA sends 8 bits LSB first using a 3-bit index; after bit 7 it proceeds to STOP (or PARITY).
REQ-024 STOP drives tx=1; on completion it returns to IDLE.
- If the FIFO is non-empty at that moment, the next frame starts on the following cycle, so there is exactly one idle cycle between frames.
REQ-025 tx is driven from a register with no combinational path to the output.
REQ-026 Latency: a DATA store at edge N into an empty FIFO with the FSM in IDLE gives tx=0 after edge N+2.
REQ-027 Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.

Reset
REQ-028 On reset: FSM to IDLE, tx=1, FIFO emptied (pointers=0), OVF=0, baud counter and bit index = 0.
REQ-029 Reset mid-frame aborts the frame: tx=1 after the reset edge, and queued bytes are discarded.

Configuration
REQ-030 Macro UART_PARITY_EN.
- Defined: a PARITY state follows DATA and sends the even-parity bit (XOR of the 8 data bits), and STATUS bit[4] reads 1.
- Undefined: there is no PARITY state, DATA goes directly to STOP, and STATUS bit[4] reads 0.

Structure
REQ-031 Package uart_pkg holds:
- the FSM state enum;
- register offsets DATA_OFS=0 and STATUS_OFS=4;
- STATUS bit indices.
REQ-032 The FIFO is a sub-module uart_tx_fifo, parameterized by width 8 and FIFO_DEPTH, with full/empty flags and simultaneous push/pop support; it has no bypass.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Store 32'h0000_00A5 to BASE -> tx low 2 cycles later, then the bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; STATUS reads 0x2 after completion.
REQ-034 Six back-to-back DATA stores with the first frame in flight -> 4 bytes are queued plus 1 popped, one byte is dropped, and STATUS reads 0xD (OVF, BUSY, FULL).
REQ-035 Store writeData=8 to BASE+4 -> OVF clears; clear and overflow in the same cycle -> OVF stays 1.
REQ-036 Reset asserted at cycle 15 of a frame -> tx=1 next cycle, STATUS=0x2, and no further frames.
REQ-037 With UART_PARITY_EN, store 8'h07 -> parity bit 1 and frame length 44 cycles; without it -> 40 cycles.
REQ-038 Load from BASE+0x100 -> hit=0 and readData=0.
